uart_tx_arbiter: RTL

Round-robin scheduler that shares the single `uart` transmitter between several byte producers. It accepts one byte at a time from up to `NUM_REQ` requesters over valid/ready handshakes and drives the UART's `tx_en`/`tx_data` pair. It uses `uart_tx_busy` as the launch acknowledge and completion indicator. It sits between application logic (LED/status reporters, debug dumpers) and the `uart` instance in the top level.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    localparam int UART_DATA_W        = 8;
    localparam int DEF_LAUNCH_TIMEOUT = 1024;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder: first valid index at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] slot;

    // Walk offsets from farthest to nearest so the nearest valid slot wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            slot = {1'b0, ptr} + (IW + 1)'(off);
            if (slot >= (IW + 1)'(N)) begin
                slot = slot - (IW + 1)'(N);
            end
            if (valid[slot[IW-1:0]]) begin
                grant              = '0;
                grant[slot[IW-1:0]] = 1'b1;
                idx                = slot[IW-1:0];
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte scheduler feeding one UART transmitter
// Optional multi-byte lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]               req_lock,
`endif
    output logic                             tx_en,
    output logic [UART_DATA_W-1:0]           tx_data,
    input  logic                             uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LAUNCH_TIMEOUT);

    arb_state_t          state, state_next;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       tmo_cnt;
    logic [NUM_REQ-1:0]  pick_mask, pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                grant_fire, timeout_hit, drain_done;
    logic                lock_keep, lock_release;
    logic [IW-1:0]       lock_owner;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] g);
        return (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_active;

    // While locked, the pick is narrowed to the owner even if it has no byte ready.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (drain_done && lock_keep) begin
            lock_active <= 1'b1;
            lock_owner  <= grant_id;
        end else if (timeout_hit || lock_release) begin
            lock_active <= 1'b0;
        end
    end

    assign lock_keep    = req_lock[grant_id];
    assign lock_release = lock_active && (state == IDLE) && !req_lock[lock_owner];
    assign pick_mask    = lock_active ? (NUM_REQ'(1) << lock_owner) : '1;
`else
    assign lock_keep    = 1'b0;
    assign lock_release = 1'b0;
    assign lock_owner   = '0;
    assign pick_mask    = '1;
`endif

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
        .valid (req_valid & pick_mask),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign grant_fire  = (state == IDLE) && !uart_tx_busy && pick_any && !lock_release;
    assign timeout_hit = (state == LAUNCH) && !uart_tx_busy && (tmo_cnt == CW'(LAUNCH_TIMEOUT - 1));
    assign drain_done  = (state == DRAIN) && !uart_tx_busy;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fire) state_next = LAUNCH;
            LAUNCH:  if (uart_tx_busy) state_next = DRAIN;
                     else if (timeout_hit) state_next = IDLE;
            DRAIN:   if (!uart_tx_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant_fire ? pick_grant : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_en       <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
        end else begin
            tx_en       <= (state_next == LAUNCH);
            err_timeout <= timeout_hit;
            if (grant_fire) begin
                tx_data  <= req_data[int'(pick_idx) * UART_DATA_W +: UART_DATA_W];
                grant_id <= pick_idx;
                tmo_cnt  <= '0;
            end else if (state == LAUNCH) begin
                tmo_cnt  <= tmo_cnt + 1'b1;
            end
            if (timeout_hit || (drain_done && !lock_keep)) begin
                rr_ptr <= wrap_inc(grant_id);
            end else if (lock_release) begin
                rr_ptr <= wrap_inc(lock_owner);
            end
        end
    end

endmodule
